// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for hazard detection: register constants,
// MDU latency default and the hazard control bundle.
package pipe_pkg;

  localparam logic [4:0]  REG_ZERO            = 5'd0;
  localparam int unsigned MDU_LATENCY_DEFAULT = 32;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t CTRL_RUN    = hazard_ctrl_t'(4'b1100);
  localparam hazard_ctrl_t CTRL_STALL  = hazard_ctrl_t'(4'b0001);
  localparam hazard_ctrl_t CTRL_SQUASH = hazard_ctrl_t'(4'b1111);

endpackage

// File: rtl/mdu_busy_counter.sv
// Tracks MDU occupancy: loads a countdown on issue, busy while it is non-zero.
module mdu_busy_counter
  import pipe_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = MDU_LATENCY_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(MDU_LATENCY);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Issue reloads; otherwise count down to idle.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CNT_W'(MDU_LATENCY - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      busy  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      busy  <= (cnt_d != '0);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use and MDU stalls, branch flushes, and a
// saturating stall-cycle counter.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = MDU_LATENCY_DEFAULT,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             IF_ID_RSAddress,
  input  logic [4:0]             IF_ID_RTAddress,
  input  logic                   IF_ID_UsesRT,
  input  logic                   IF_ID_UsesHiLo,
  input  logic                   IF_ID_IsMDU,
  input  logic                   ID_EX_MemRead,
  input  logic [4:0]             ID_EX_RTAddress,
  input  logic                   EX_MDUStart,
  input  logic                   EX_BranchTaken,
  output logic                   PCWrite,
  output logic                   IF_ID_Write,
  output logic                   IF_ID_Flush,
  output logic                   ID_EX_Flush,
  output logic                   MDUBusy,
  output logic [STALL_CNT_W-1:0] StallCount
);

  logic         mdu_busy_q;
  logic         load_use;
  logic         mdu_stall;
  logic         stall;
  hazard_ctrl_t ctrl;

  // A squashed MDU op never occupies the unit.
  mdu_busy_counter #(
    .MDU_LATENCY (MDU_LATENCY)
  ) u_mdu_busy (
    .clk   (clk),
    .rst   (rst),
    .start (EX_MDUStart && !EX_BranchTaken),
    .busy  (mdu_busy_q)
  );

  assign MDUBusy = mdu_busy_q && !rst;

  always_comb begin
    load_use  = ID_EX_MemRead && (ID_EX_RTAddress != REG_ZERO) &&
                ((ID_EX_RTAddress == IF_ID_RSAddress) ||
                 (IF_ID_UsesRT && (ID_EX_RTAddress == IF_ID_RTAddress)));
    mdu_stall = MDUBusy && (IF_ID_UsesHiLo || IF_ID_IsMDU);
    stall     = load_use || mdu_stall;
  end

  // Branch squashes the stalled instruction, so it outranks any stall.
  always_comb begin
    ctrl = CTRL_RUN;
    if (rst) begin
      ctrl = CTRL_RUN;
    end else if (EX_BranchTaken) begin
      ctrl = CTRL_SQUASH;
    end else if (stall) begin
      ctrl = CTRL_STALL;
    end
  end

  assign PCWrite     = ctrl.pc_write;
  assign IF_ID_Write = ctrl.if_id_write;
  assign IF_ID_Flush = ctrl.if_id_flush;
  assign ID_EX_Flush = ctrl.id_ex_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      StallCount <= '0;
    end else if (stall && !EX_BranchTaken && (StallCount != '1)) begin
      StallCount <= StallCount + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: driver pushes model expectations, a
// negedge monitor pops and compares against the DUT.
module tb_hazard_unit;

  localparam int unsigned LAT   = 4;
  localparam int unsigned CW    = 16;
  localparam int          CMAX  = (1 << CW) - 1;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       hilo;
    logic       is_mdu;
    logic       mem_read;
    logic [4:0] ex_rt;
    logic       mdu_start;
    logic       br;
    logic       rst;
  } stim_t;

  typedef struct {
    logic [3:0] ctrl;
    logic       busy;
    int         cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    IF_ID_RSAddress, IF_ID_RTAddress, ID_EX_RTAddress;
  logic          IF_ID_UsesRT, IF_ID_UsesHiLo, IF_ID_IsMDU, ID_EX_MemRead;
  logic          EX_MDUStart, EX_BranchTaken;
  logic          PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MDUBusy;
  logic [CW-1:0] StallCount;

  hazard_unit #(.MDU_LATENCY(LAT), .STALL_CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .IF_ID_RSAddress (IF_ID_RSAddress),
    .IF_ID_RTAddress (IF_ID_RTAddress),
    .IF_ID_UsesRT    (IF_ID_UsesRT),
    .IF_ID_UsesHiLo  (IF_ID_UsesHiLo),
    .IF_ID_IsMDU     (IF_ID_IsMDU),
    .ID_EX_MemRead   (ID_EX_MemRead),
    .ID_EX_RTAddress (ID_EX_RTAddress),
    .EX_MDUStart     (EX_MDUStart),
    .EX_BranchTaken  (EX_BranchTaken),
    .PCWrite         (PCWrite),
    .IF_ID_Write     (IF_ID_Write),
    .IF_ID_Flush     (IF_ID_Flush),
    .ID_EX_Flush     (ID_EX_Flush),
    .MDUBusy         (MDUBusy),
    .StallCount      (StallCount)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   tests  = 0;
  int   errors = 0;

  // Reference model: absolute cycle the MDU frees up, and a plain stall tally.
  int cyc      = 0;
  int busy_end = 0;
  int cnt      = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    logic lu, ms, busy;
    @(posedge clk);
    #1;
    cyc++;
    rst             = s.rst;
    IF_ID_RSAddress = s.rs;
    IF_ID_RTAddress = s.rt;
    IF_ID_UsesRT    = s.uses_rt;
    IF_ID_UsesHiLo  = s.hilo;
    IF_ID_IsMDU     = s.is_mdu;
    ID_EX_MemRead   = s.mem_read;
    ID_EX_RTAddress = s.ex_rt;
    EX_MDUStart     = s.mdu_start;
    EX_BranchTaken  = s.br;
    busy = !s.rst && (cyc < busy_end);
    lu   = s.mem_read && (s.ex_rt != 5'd0) &&
           ((s.ex_rt == s.rs) || (s.uses_rt && (s.ex_rt == s.rt)));
    ms   = busy && (s.hilo || s.is_mdu);
    if (s.rst)          e.ctrl = 4'b1100;
    else if (s.br)      e.ctrl = 4'b1111;
    else if (lu || ms)  e.ctrl = 4'b0001;
    else                e.ctrl = 4'b1100;
    e.busy = busy;
    e.cnt  = cnt;
    exp_q.push_back(e);
    if (s.rst) begin
      cnt      = 0;
      busy_end = 0;
    end else begin
      if ((lu || ms) && !s.br && cnt < CMAX) cnt++;
      if (s.mdu_start && !s.br) busy_end = cyc + LAT;
    end
  endtask

  // Monitor: one expectation per driven cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ctrl", int'({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}), int'(e.ctrl));
      check("mdu_busy", int'(MDUBusy), int'(e.busy));
      check("stall_count", int'(StallCount), e.cnt);
      if (EX_MDUStart) check("mdu_start_while_busy", int'(MDUBusy), 0);
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rs = 5'd1;
    s.rt = 5'd2;
    return s;
  endfunction

  initial begin
    stim_t s;
    rst = 1'b1;
    IF_ID_RSAddress = '0; IF_ID_RTAddress = '0; ID_EX_RTAddress = '0;
    IF_ID_UsesRT = 0; IF_ID_UsesHiLo = 0; IF_ID_IsMDU = 0; ID_EX_MemRead = 0;
    EX_MDUStart = 0; EX_BranchTaken = 0;
    repeat (2) @(posedge clk);

    // reset-state cycle
    s = idle(); s.rst = 1'b1; step(s);

    // lw $8 then rs=8 use
    s = idle(); s.mem_read = 1; s.ex_rt = 5'd8; s.rs = 5'd8; step(s);
    s = idle(); s.rs = 5'd8; step(s);

    // $0 never stalls; rt only matters when read
    s = idle(); s.mem_read = 1; s.ex_rt = 5'd0; s.rs = 5'd0; step(s);
    s = idle(); s.mem_read = 1; s.ex_rt = 5'd9; s.rt = 5'd9; step(s);
    s.uses_rt = 1; step(s);

    // MDU issue, mfhi waits through busy window
    s = idle(); s.mdu_start = 1; step(s);
    s = idle(); s.hilo = 1;
    repeat (LAT) step(s);

    // load-use under a taken branch
    s = idle(); s.mem_read = 1; s.ex_rt = 5'd5; s.rs = 5'd5; s.br = 1; step(s);

    // reset mid-countdown
    s = idle(); s.mdu_start = 1; step(s);
    s = idle(); s.is_mdu = 1; step(s); step(s);
    s.rst = 1; step(s);
    s.rst = 0; step(s);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      s.rs        = 5'($urandom_range(0, 3));
      s.rt        = 5'($urandom_range(0, 3));
      s.ex_rt     = 5'($urandom_range(0, 3));
      s.uses_rt   = 1'($urandom);
      s.hilo      = ($urandom_range(0, 3) == 0);
      s.is_mdu    = ($urandom_range(0, 5) == 0);
      s.mem_read  = 1'($urandom);
      s.br        = ($urandom_range(0, 7) == 0);
      s.rst       = ($urandom_range(0, 63) == 0);
      s.mdu_start = ($urandom_range(0, 4) == 0) && !((cyc + 1) < busy_end);
      step(s);
    end

    // saturation
    s = idle(); s.rst = 1; step(s);
    s = idle(); s.mem_read = 1; s.ex_rt = 5'd3; s.rs = 5'd3;
    repeat (CMAX + 4) step(s);
    s = idle(); step(s);

    @(posedge clk);
    @(negedge clk);
    #1;
    check("stall_count_saturated", int'(StallCount), CMAX);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
